// File: rtl/dcache_ctrl_pkg.sv
// Shared types and sizes for the direct-mapped write-back data cache.
package dcache_ctrl_pkg;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_BITS      = 128;
  localparam int MEM_ADDR_W     = 28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;
endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port, clocked fill and word-write ports.
module dcache_line_array
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = $clog2(NUM_BLOCKS),
  parameter int TAG_W      = MEM_ADDR_W - IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 word_we,
  input  logic [IDX_W-1:0]     word_idx,
  input  logic [1:0]           word_sel,
  input  logic [31:0]          word_data,
  input  logic                 fill_we,
  input  logic [IDX_W-1:0]     fill_idx,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_line
);
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_BITS-1:0]  line_q [NUM_BLOCKS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = line_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[fill_idx] <= 1'b1;
      dirty_q[fill_idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[word_idx] <= 1'b1;
    end
  end

  // Tags and data are qualified by valid, so they keep no reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      line_q[fill_idx] <= fill_line;
    end else if (word_we) begin
      line_q[word_idx][{word_sel, 5'd0} +: 32] <= word_data;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller (IDLE/WRITEBACK/ALLOCATE).
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [29:0]           proc_addr,
  input  logic [31:0]           proc_wdata,
  output logic                  proc_stall,
  output logic [31:0]           proc_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_BITS-1:0]  mem_wdata,
  input  logic [LINE_BITS-1:0]  mem_rdata,
  input  logic                  mem_ready,
  output state_t                dbg_state
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  state_t                 state;
  logic [MEM_ADDR_W-1:0]  pend_line;
  logic                   req, hit;
  logic [MEM_ADDR_W-1:0]  line_addr;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   rd_valid, rd_dirty;
  logic [TAG_W-1:0]       rd_tag;
  logic [LINE_BITS-1:0]   rd_line;

  assign req       = proc_read | proc_write;
  assign line_addr = proc_addr[29:2];
  assign idx       = line_addr[IDX_W-1:0];
  assign tag       = line_addr[MEM_ADDR_W-1:IDX_W];
  assign hit       = (state == IDLE) && req && rd_valid && (rd_tag == tag);
  assign dbg_state = state;

  // Reset forces stall low immediately, even with a request pending.
  assign proc_stall = !rst && ((state != IDLE) || (req && !hit));

  always_comb begin
    proc_rdata = '0;
    if (hit && !proc_write) proc_rdata = rd_line[{proc_addr[1:0], 5'd0} +: 32];
  end

  dcache_line_array #(.NUM_BLOCKS(NUM_BLOCKS)) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_we   (hit && proc_write),
    .word_idx  (idx),
    .word_sel  (proc_addr[1:0]),
    .word_data (proc_wdata),
    .fill_we   ((state == ALLOCATE) && mem_ready),
    .fill_idx  (pend_line[IDX_W-1:0]),
    .fill_tag  (pend_line[MEM_ADDR_W-1:IDX_W]),
    .fill_line (mem_rdata)
  );

  // Memory handshake: mem_read/mem_write are held, with mem_addr/mem_wdata stable,
  // until a single-cycle mem_ready completes the transfer; mem_ready is ignored in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pend_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            pend_line <= line_addr;
            if (rd_valid && rd_dirty) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {rd_tag, idx};
              mem_wdata <= rd_line;
            end else begin
              state    <= ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= line_addr;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            state     <= ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= pend_line;
            mem_wdata <= '0;
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_read <= 1'b0;
            mem_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed and randomized checks of dcache_ctrl against a line-level cache/memory model.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  state_t       dbg_state;

  int checks   = 0;
  int failures = 0;

  // Model: main memory keyed by line address, plus per-index cache contents.
  logic [127:0] mem_model [int];
  bit           m_valid [NB];
  bit           m_dirty [NB];
  int           m_tag   [NB];
  logic [127:0] m_data  [NB];

  always #5 clk = ~clk;

  dcache_ctrl #(.NUM_BLOCKS(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input int line);
    if (!mem_model.exists(line)) mem_model[line] = {$urandom, $urandom, $urandom, $urandom};
    return mem_model[line];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One memory transfer: request visible for delay+1 cycles, mem_ready in the last.
  task automatic serve(input string tag, input bit is_wr, input int exp_line,
                       input logic [127:0] exp_wdata, input int delay, input logic [127:0] rdata);
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      mem_ready = (i == delay);
      mem_rdata = rdata;
      #1;
      chk({tag, "_mem_write"}, mem_write, is_wr);
      chk({tag, "_mem_read"}, mem_read, !is_wr);
      chk({tag, "_mem_addr"}, mem_addr, 28'(exp_line));
      if (is_wr) chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
      chk({tag, "_stall"}, proc_stall, 1'b1);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [29:0] addr,
                        input logic [31:0] wdata, input int delay);
    int line, idx, tg, w, victim;
    bit hit;
    logic [127:0] fill;
    line = int'(addr >> 2);
    idx  = line % NB;
    tg   = line / NB;
    w    = int'(addr[1:0]);
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    @(negedge clk);
    mem_ready  = 1'b0;
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wdata;
    #1;
    if (!hit) begin
      chk("miss_stall", proc_stall, 1'b1);
      chk("miss_idle_mem_read", mem_read, 1'b0);
      chk("miss_idle_mem_write", mem_write, 1'b0);
      if (m_valid[idx] && m_dirty[idx]) begin
        victim = m_tag[idx] * NB + idx;
        serve("writeback", 1'b1, victim, m_data[idx], delay, {4{$urandom}});
        mem_model[victim] = m_data[idx];
      end
      fill = mem_line(line);
      serve("allocate", 1'b0, line, '0, delay, fill);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = fill;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
    end
    chk("access_stall", proc_stall, 1'b0);
    chk("access_mem_read", mem_read, 1'b0);
    chk("access_mem_write", mem_write, 1'b0);
    if (wr) begin
      chk("write_rdata", proc_rdata, 32'h0);
      m_data[idx][w*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end else begin
      chk("read_rdata", proc_rdata, m_data[idx][w*32 +: 32]);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    proc_read  = 1'b0;
    proc_write = 1'b0;
    mem_ready  = 1'b0;
    #1;
    chk("idle_stall", proc_stall, 1'b0);
    chk("idle_rdata", proc_rdata, 32'h0);
  endtask

  initial begin
    int op, tg, idx, w;
    rst = 1'b1;
    proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", proc_stall, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 28'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    chk("rst_rdata", proc_rdata, 32'h0);
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Cold read miss with a three-cycle memory wait.
    mem_model[4] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    access(1'b1, 1'b0, 30'h10, 32'h0, 3);
    chk("cold_read_word0", proc_rdata, 32'h1111_1111);

    // Write hit then read back with no memory traffic.
    access(1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF, 0);
    access(1'b1, 1'b0, 30'h11, 32'h0, 0);
    chk("write_hit_readback", proc_rdata, 32'hDEAD_BEEF);

    // Conflict miss on a dirty victim: write-back of line 0x4 then fill of 0x84.
    access(1'b1, 1'b0, 30'h211, 32'h0, 2);
    chk("dirty_victim_saved", mem_model[4][63:32], 32'hDEAD_BEEF);

    // Read and write together behave as a write.
    access(1'b1, 1'b1, 30'h211, 32'h1234_5678, 0);
    access(1'b1, 1'b0, 30'h211, 32'h0, 0);
    chk("rw_as_write_readback", proc_rdata, 32'h1234_5678);

    // Stray mem_ready in IDLE with no request.
    @(negedge clk);
    proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b1;
    #1;
    chk("stray_ready_stall", proc_stall, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("stray_ready_state", dbg_state, IDLE);
    chk("stray_ready_mem_read", mem_read, 1'b0);
    chk("stray_ready_mem_write", mem_write, 1'b0);
    chk("stray_ready_mem_addr", mem_addr, 28'h0);
    chk("stray_ready_rdata", proc_rdata, 32'h0);
    access(1'b1, 1'b0, 30'h211, 32'h0, 0);

    // Reset in the middle of ALLOCATE (after the dirty write-back completes).
    @(negedge clk);
    proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h10;
    #1;
    chk("mid_rst_miss_stall", proc_stall, 1'b1);
    serve("mid_rst_wb", 1'b1, 'h84, m_data[4], 1, {4{$urandom}});
    mem_model['h84] = m_data[4];
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("mid_rst_alloc_read", mem_read, 1'b1);
    chk("mid_rst_alloc_addr", mem_addr, 28'h4);
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_read", mem_read, 1'b0);
    chk("mid_rst_stall", proc_stall, 1'b0);
    chk("mid_rst_state", dbg_state, IDLE);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    proc_read = 1'b0;
    access(1'b1, 1'b0, 30'h10, 32'h0, 1);
    chk("post_rst_word0", proc_rdata, 32'h1111_1111);

    // Randomized traffic over four tags per index to force hits, conflicts and write-backs.
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 2);
      tg  = $urandom_range(0, 3);
      idx = $urandom_range(0, NB - 1);
      w   = $urandom_range(0, 3);
      access(op != 1, op != 0, 30'(((tg * NB + idx) * 4) + w), $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
